// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Access size encodings, FSM states and the alignment check.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    // High when the access is misaligned or the size is illegal
    function automatic logic size_error(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic err;
        err = 1'b1;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = lo[0];
            SZ_WORD: err = |lo;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Byte/halfword lane handling for the load/store unit.
// Extracts and extends load lanes; merges store lanes into a read word.
import lsu_pkg::*;

module lsu_lane_merge (
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select lanes little-endian; word accesses pass straight through
    always_comb begin
        byte_v  = rd_word_i[{lane_i, 3'b000} +: 8];
        half_v  = rd_word_i[{lane_i[1], 4'b0000} +: 16];
        load_o  = rd_word_i;
        merge_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{24{~unsigned_i & byte_v[7]}}, byte_v};
                merge_o = old_word_i;
                merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o  = {{16{~unsigned_i & half_v[15]}}, half_v};
                merge_o = old_word_i;
                merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                load_o  = rd_word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the CPU and a word-wide data memory.
// Sub-word stores use read-modify-write; bad accesses answer with an error.
import lsu_pkg::*;

module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_write,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    state_t                state_q, state_d;
    logic                  write_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  req_err;
    logic                  accept;
    logic [DATA_WIDTH-1:0] load_w;
    logic [DATA_WIDTH-1:0] merge_w;

    assign req_err = size_error(req_size, req_addr[1:0]);
    assign accept  = (state_q == S_IDLE) && req_valid;

    lsu_lane_merge u_lane (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .lane_i     (addr_q[1:0]),
        .rd_word_i  (mem_data_out),
        .old_word_i (old_q),
        .wdata_i    (wdata_q),
        .load_o     (load_w),
        .merge_o    (merge_w)
    );

    // State and datapath registers; requests only sampled in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= req_write;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
            if (state_q == S_READ) begin
                if (write_q) begin
                    old_q <= mem_data_out;
                end else begin
                    rdata_q <= load_w;
                end
            end
        end
    end

    // Next-state: errors skip memory, word stores skip the read
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (req_write && req_size == SZ_WORD) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = write_q ? S_WRITE : S_RESP;
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are masked by reset so an aborted access never writes
    always_comb begin
        req_ready      = (state_q == S_IDLE);
        resp_valid     = (state_q == S_RESP);
        resp_error     = (state_q == S_RESP) && err_q;
        resp_rdata     = rdata_q;
        mem_address    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_read_en    = (state_q == S_READ) && !reset;
        mem_write_en   = (state_q == S_WRITE) && !reset;
        mem_data_write = mem_write_en ? merge_w : '0;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 req_valid  input  1  CPU access request present.
REQ-006 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  load zero-extends when high and sign-extends when low.
REQ-010 req_addr  input  ADDR_WIDTH  byte address.
REQ-011 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  DATA_WIDTH  extended load data; holds until the next response.
REQ-014 resp_error  output  1  misaligned or illegal size; valid with resp_valid.
REQ-015 mem_address  output  ADDR_WIDTH  word-aligned address to data memory ({addr[31:2],2'b00}).
REQ-016 mem_data_write  output  DATA_WIDTH  word written to memory.
REQ-017 mem_write_en / mem_read_en  output  1 each  memory strobes.
REQ-018 mem_data_out  input  DATA_WIDTH  memory read data, combinational from mem_address while mem_read_en is high.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-020 IDLE with req_valid SHALL latch all req_* fields, and no other state SHALL sample req_*.
REQ-021 Alignment check: halfword requires addr[0]=0, word requires addr[1:0]=0, and size 11 is always an error.
REQ-022 An error request SHALL go IDLE->RESP with resp_error=1, resp_rdata unchanged, and no memory strobe.
REQ-023 Load SHALL go IDLE->READ->RESP, so resp_valid is asserted 2 cycles after acceptance.
REQ-024 Word store SHALL go IDLE->WRITE->RESP, with mem_write_en high for exactly one cycle.
REQ-025 Byte/halfword store SHALL do read-modify-write: IDLE->READ->WRITE->RESP.
REQ-026 In the RMW WRITE cycle, only the addressed lanes SHALL be replaced and the other lanes SHALL keep the word read in READ.
REQ-027 mem_read_en SHALL be high only in READ, and mem_data_out SHALL be sampled only at the end of READ.
REQ-028 mem_write_en SHALL be high only in WRITE, and it SHALL never be high together with mem_read_en.
REQ-029 Byte lanes are little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; halfword h = bits [16h+15:16h], h = addr[1].
REQ-030 Loads SHALL extract the addressed lane and extend it to 32 bits per req_unsigned; word loads pass through unchanged.
REQ-031 RESP SHALL return to IDLE unconditionally, and a request may be accepted in the cycle after RESP.
REQ-032 Outside READ/WRITE, mem_address SHALL hold the last latched aligned address and mem_data_write SHALL be 0.

Reset
REQ-033 Reset SHALL force IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_*_en=0, mem_address=0, and mem_data_write=0.
REQ-034 Reset mid-operation SHALL abort without a response, and no memory write SHALL occur in the reset cycle or after it.
REQ-035 If reset and req_valid are high together, reset SHALL win and the request is dropped.

Structure
REQ-036 Package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-037 Sub-module lsu_lane_merge (combinational) SHALL hold lane extract/extend and lane merge; the FSM and registers stay in load_store_unit.

Verification
REQ-038 Memory word 0x10 = 0x8899AABB; lb addr 0x11 signed -> resp_rdata 0xFFFFFFAA two cycles after acceptance; lbu -> 0x000000AA.
REQ-039 sb 0x5C to addr 0x12 over word 0x8899AABB -> READ then WRITE of 0x885CAABB at mem_address 0x10; resp_error=0.
REQ-040 sw 0xDEADBEEF to addr 0x20 -> single write cycle, no read strobe, response on the next cycle; following lw addr 0x20 returns 0xDEADBEEF.
REQ-041 lh addr 0x13 and sw addr 0x22 -> resp_error=1, no strobes, resp_rdata unchanged; req_size=11 -> same.
REQ-042 Reset asserted during READ of sh -> no mem_write_en pulse, no resp_valid, req_ready=1 on the next cycle.
REQ-043 Back-to-back requests with req_valid held high -> each is accepted only while req_ready=1, and no request is lost or duplicated.
